// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
// Shared definitions for the timer loader: FSM state enum, digit count,
// default digit limits and the BCD digit type.
// Build option: TIMER_LOADER_PAUSE_EN adds the PAUSED state to the enum.
// -----------------------------------------------------------------------------
package timer_pkg;

   localparam int NUM_DIGITS       = 4;
   localparam int UNIT_MAX_DEFAULT = 9;
   localparam int TENS_MAX_DEFAULT = 5;

   typedef logic [3:0] bcd_t;

`ifdef TIMER_LOADER_PAUSE_EN
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_PAUSED,
      ST_DONE
   } state_t;
`else
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;
`endif

   // Digit idx counted from the most significant end: 0=mt, 1=mu, 2=st, 3=su.
   function automatic bcd_t msd_digit(input logic [4*NUM_DIGITS-1:0] e,
                                      input logic [1:0]              idx);
      bcd_t d;
      case (idx)
         2'd0:    d = e[15:12];
         2'd1:    d = e[11:8];
         2'd2:    d = e[7:4];
         default: d = e[3:0];
      endcase
      return d;
   endfunction

endpackage

// File: rtl/digit_entry_reg.sv
// -----------------------------------------------------------------------------
// digit_entry_reg
// Four-digit BCD entry register. A shift moves every digit one place towards
// the most significant end and inserts the new digit as the least significant
// one; the top digit is discarded. Clear zeroes all digits; clear together
// with shift leaves only the new digit (used when leaving DONE on a keypress).
//
// Ports
//   clk    : clock
//   rst    : synchronous active-high reset, zeroes the entry
//   clear  : zero the entry on the next edge
//   shift  : shift digit in on the next edge
//   digit  : digit inserted by shift
//   entry  : {mt,mu,st,su}
// -----------------------------------------------------------------------------
module digit_entry_reg
   import timer_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clear,
   input  logic                    shift,
   input  bcd_t                    digit,
   output logic [4*NUM_DIGITS-1:0] entry
);

   genvar gi;
   generate
      for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         bcd_t digit_reg;
         bcd_t shift_src;
         bcd_t clear_val;

         if (gi == 0) begin : g_lsd
            assign shift_src = digit;
            assign clear_val = shift ? digit : '0;
         end else begin : g_upper
            assign shift_src = entry[4*(gi-1) +: 4];
            assign clear_val = '0;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               digit_reg <= '0;
            end else if (clear) begin
               digit_reg <= clear_val;
            end else if (shift) begin
               digit_reg <= shift_src;
            end
         end

         assign entry[4*gi +: 4] = digit_reg;
      end
   endgenerate

endmodule

// File: rtl/timer_loader.sv
// -----------------------------------------------------------------------------
// timer_loader
// Collects a keyed mm:ss time as four BCD digits, validates it on start,
// serially loads it into a downstream countdown timer (mt, mu, st, su) and
// then enables the timer until it reports completion.
// Build option: define TIMER_LOADER_PAUSE_EN to add pause/resume from RUN.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   digit_in     : keyed BCD digit, qualified by digit_valid
//   start        : load the entered time and run
//   cancel       : abort from any state and clear the entry
//   pause        : pause/resume toggle (only with TIMER_LOADER_PAUSE_EN)
//   finished_in  : countdown complete from the timer
//   load         : serial-load strobe, load_digit valid while high
//   enablen      : active-low count enable
//   entry        : {mt,mu,st,su} for display
//   busy         : state is not IDLE
//   err          : one-cycle pulse on a rejected digit or start
// -----------------------------------------------------------------------------
module timer_loader
   import timer_pkg::*;
#(
   parameter int UNIT_MAX = UNIT_MAX_DEFAULT,
   parameter int TENS_MAX = TENS_MAX_DEFAULT
)(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [3:0]              digit_in,
   input  logic                    digit_valid,
   input  logic                    start,
   input  logic                    cancel,
   input  logic                    pause,
   input  logic                    finished_in,
   output logic                    load,
   output logic [3:0]              load_digit,
   output logic                    enablen,
   output logic [4*NUM_DIGITS-1:0] entry,
   output logic                    busy,
   output logic                    err
);

   localparam bcd_t UNIT_MAX_D = bcd_t'(UNIT_MAX);
   localparam bcd_t TENS_MAX_D = bcd_t'(TENS_MAX);
   localparam logic [2:0] LOAD_LAST = 3'(NUM_DIGITS);

   state_t     state_reg;
   logic [2:0] load_cnt_reg;
   logic       load_reg;
   bcd_t       load_digit_reg;
   logic       enablen_reg;
   logic       busy_reg;
   logic       err_reg;

   logic digit_ok;
   logic tens_bad;
   logic entry_zero;
   logic entry_clear;
   logic entry_shift;

   assign digit_ok   = (digit_in <= UNIT_MAX_D);
   assign tens_bad   = (entry[15:12] > TENS_MAX_D) || (entry[7:4] > TENS_MAX_D);
   assign entry_zero = (entry == '0);

   // Keypresses are taken in IDLE and DONE only; in DONE the old time is
   // dropped so the new digit starts a fresh entry.
   assign entry_clear = cancel || (state_reg == ST_DONE && digit_valid);
   assign entry_shift = !cancel && digit_valid && digit_ok &&
                        (state_reg == ST_IDLE || state_reg == ST_DONE);

`ifndef TIMER_LOADER_PAUSE_EN
   logic unused_pause;
   assign unused_pause = pause;
`endif

   digit_entry_reg u_entry (
      .clk   (clk),
      .rst   (rst),
      .clear (entry_clear),
      .shift (entry_shift),
      .digit (digit_in),
      .entry (entry)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg      <= ST_IDLE;
         load_cnt_reg   <= '0;
         load_reg       <= 1'b0;
         load_digit_reg <= '0;
         enablen_reg    <= 1'b1;
         busy_reg       <= 1'b0;
         err_reg        <= 1'b0;
      end else begin
         err_reg <= 1'b0;
         if (cancel) begin
            state_reg      <= ST_IDLE;
            load_cnt_reg   <= '0;
            load_reg       <= 1'b0;
            load_digit_reg <= '0;
            enablen_reg    <= 1'b1;
            busy_reg       <= 1'b0;
         end else begin
            case (state_reg)
               ST_IDLE: begin
                  // A keypress wins over start in the same cycle.
                  if (digit_valid) begin
                     err_reg <= !digit_ok;
                  end else if (start) begin
                     if (tens_bad || entry_zero) begin
                        err_reg <= 1'b1;
                     end else begin
                        state_reg      <= ST_LOAD;
                        load_reg       <= 1'b1;
                        load_digit_reg <= msd_digit(entry, 2'd0);
                        load_cnt_reg   <= 3'd1;
                        busy_reg       <= 1'b1;
                     end
                  end
               end

               ST_LOAD: begin
                  // load_cnt_reg is the index of the next digit to present;
                  // the entry cannot change while loading.
                  if (load_cnt_reg == LOAD_LAST) begin
                     state_reg      <= ST_RUN;
                     load_reg       <= 1'b0;
                     load_digit_reg <= '0;
                     load_cnt_reg   <= '0;
                     enablen_reg    <= 1'b0;
                  end else begin
                     load_digit_reg <= msd_digit(entry, load_cnt_reg[1:0]);
                     load_cnt_reg   <= load_cnt_reg + 3'd1;
                  end
               end

               ST_RUN: begin
                  if (finished_in) begin
                     state_reg   <= ST_DONE;
                     enablen_reg <= 1'b1;
                  end
`ifdef TIMER_LOADER_PAUSE_EN
                  else if (pause) begin
                     state_reg   <= ST_PAUSED;
                     enablen_reg <= 1'b1;
                  end
`endif
               end

`ifdef TIMER_LOADER_PAUSE_EN
               ST_PAUSED: begin
                  // Timer is halted, so a completion flag here is stale.
                  if (pause) begin
                     state_reg   <= ST_RUN;
                     enablen_reg <= 1'b0;
                  end
               end
`endif

               ST_DONE: begin
                  if (digit_valid) begin
                     state_reg <= ST_IDLE;
                     busy_reg  <= 1'b0;
                     err_reg   <= !digit_ok;
                  end
               end

               default: begin
                  state_reg      <= ST_IDLE;
                  load_reg       <= 1'b0;
                  load_digit_reg <= '0;
                  enablen_reg    <= 1'b1;
                  busy_reg       <= 1'b0;
               end
            endcase
         end
      end
   end

   assign load       = load_reg;
   assign load_digit = load_digit_reg;
   assign enablen    = enablen_reg;
   assign busy       = busy_reg;
   assign err        = err_reg;

endmodule

// File: tb/tb_timer_loader.sv
module tb_timer_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  digit_in;
   logic        digit_valid;
   logic        start;
   logic        cancel;
   logic        pause;
   logic        finished_in;
   logic        load;
   logic [3:0]  load_digit;
   logic        enablen;
   logic [15:0] entry;
   logic        busy;
   logic        err;

   int errors = 0;
   int checks = 0;

   timer_loader dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_valid (digit_valid),
      .start       (start),
      .cancel      (cancel),
      .pause       (pause),
      .finished_in (finished_in),
      .load        (load),
      .load_digit  (load_digit),
      .enablen     (enablen),
      .entry       (entry),
      .busy        (busy),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] d);
      digit_in    = d;
      digit_valid = 1'b1;
      cyc();
      digit_valid = 1'b0;
      $display("key %0h -> entry=%04h err=%0b busy=%0b", d, entry, err, busy);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      $display("start -> load=%0b load_digit=%0h err=%0b busy=%0b", load, load_digit, err, busy);
   endtask

   task automatic pulse_cancel();
      cancel = 1'b1;
      cyc();
      cancel = 1'b0;
      $display("cancel -> entry=%04h busy=%0b", entry, busy);
   endtask

   task automatic pulse_finished();
      finished_in = 1'b1;
      cyc();
      finished_in = 1'b0;
      $display("finished_in -> enablen=%0b busy=%0b", enablen, busy);
   endtask

   task automatic pulse_pause();
      pause = 1'b1;
      cyc();
      pause = 1'b0;
      $display("pause -> enablen=%0b busy=%0b", enablen, busy);
   endtask

   // Expects the four load cycles of time value t, then RUN.
   task automatic expect_load(input string tag, input logic [15:0] t);
      logic [15:0] sh;
      sh = t;
      for (int i = 0; i < 4; i++) begin
         chk({tag, "_load"}, load, 1'b1);
         chk({tag, "_ldig"}, load_digit, sh[15:12]);
         sh = sh << 4;
         cyc();
      end
      chk({tag, "_load_end"}, load, 1'b0);
      chk({tag, "_ldig_end"}, load_digit, 4'h0);
      chk({tag, "_run_en"}, enablen, 1'b0);
      chk({tag, "_run_busy"}, busy, 1'b1);
   endtask

   logic [15:0] model_entry;
   logic [3:0]  d;
   int          nkeys;
   logic        start_ok;

   initial begin
      rst = 1'b1; digit_in = '0; digit_valid = 1'b0; start = 1'b0;
      cancel = 1'b0; pause = 1'b0; finished_in = 1'b0;
      cyc(); cyc();
      rst = 1'b0;
      cyc();
      chk("rst_entry", entry, 16'h0);
      chk("rst_load", load, 1'b0);
      chk("rst_ldig", load_digit, 4'h0);
      chk("rst_en", enablen, 1'b1);
      chk("rst_err", err, 1'b0);
      chk("rst_busy", busy, 1'b0);

      // Normal load of 12:34.
      key(4'd1); key(4'd2); key(4'd3); key(4'd4);
      chk("entry_1234", entry, 16'h1234);
      pulse_start();
      expect_load("l1234", 16'h1234);

      // Pause / finished interplay.
      pulse_pause();
`ifdef TIMER_LOADER_PAUSE_EN
      chk("paused_en", enablen, 1'b1);
      pulse_finished();
      chk("paused_ignore_fin", enablen, 1'b1);
      chk("paused_busy", busy, 1'b1);
      pulse_pause();
      chk("resume_en", enablen, 1'b0);
      pulse_finished();
      chk("done_en", enablen, 1'b1);
`else
      chk("nopause_en", enablen, 1'b0);
      pulse_finished();
      chk("done_en", enablen, 1'b1);
      pulse_pause();
      pulse_finished();
      chk("done_stay_en", enablen, 1'b1);
`endif
      // DONE: start ignored, key restarts entry.
      pulse_start();
      chk("done_start_load", load, 1'b0);
      chk("done_start_busy", busy, 1'b1);
      key(4'd7);
      chk("done_key_entry", entry, 16'h0007);
      chk("done_key_busy", busy, 1'b0);
      chk("done_key_err", err, 1'b0);

      // Start and key in the same IDLE cycle: digit only.
      start = 1'b1;
      key(4'd5);
      start = 1'b0;
      chk("both_entry", entry, 16'h0075);
      chk("both_load", load, 1'b0);
      chk("both_busy", busy, 1'b0);
      cyc();
      chk("both_load2", load, 1'b0);

      // Bad tens digit.
      pulse_cancel();
      chk("cancel_entry", entry, 16'h0);
      key(4'd9); key(4'd9); key(4'd9);
      pulse_start();
      chk("tens_err", err, 1'b1);
      chk("tens_busy", busy, 1'b0);
      chk("tens_load", load, 1'b0);
      cyc();
      chk("tens_err_clr", err, 1'b0);
      chk("tens_load2", load, 1'b0);

      // Non-BCD digit and zero start.
      key(4'hA);
      chk("bad_digit_err", err, 1'b1);
      chk("bad_digit_entry", entry, 16'h0999);
      pulse_cancel();
      pulse_start();
      chk("zero_err", err, 1'b1);
      chk("zero_busy", busy, 1'b0);

      // Cancel on the second load cycle.
      key(4'd1); key(4'd2); key(4'd0); key(4'd0);
      pulse_start();
      chk("cl_first", load_digit, 4'd1);
      cyc();
      chk("cl_second", load_digit, 4'd2);
      pulse_cancel();
      chk("cl_load", load, 1'b0);
      chk("cl_en", enablen, 1'b1);
      chk("cl_entry", entry, 16'h0);
      chk("cl_busy", busy, 1'b0);
      cyc();
      chk("cl_load2", load, 1'b0);

      // Reset in the middle of a load, with cancel also high.
      key(4'd3);
      pulse_start();
      cyc();
      rst = 1'b1; cancel = 1'b1;
      cyc();
      rst = 1'b0; cancel = 1'b0;
      chk("rl_load", load, 1'b0);
      chk("rl_ldig", load_digit, 4'h0);
      chk("rl_en", enablen, 1'b1);
      chk("rl_entry", entry, 16'h0);
      chk("rl_busy", busy, 1'b0);
      chk("rl_err", err, 1'b0);

      // Randomised entry/start trials against a value-level model.
      for (int t = 0; t < 25; t++) begin
         pulse_cancel();
         model_entry = 16'h0;
         nkeys = $urandom_range(1, 6);
         for (int k = 0; k < nkeys; k++) begin
            d = 4'($urandom_range(0, 11));
            key(d);
            if (d <= 4'd9) begin
               model_entry = {model_entry[11:0], d};
               chk("rnd_key_err", err, 1'b0);
            end else begin
               chk("rnd_key_err", err, 1'b1);
            end
            chk("rnd_entry", entry, model_entry);
         end
         start_ok = (model_entry != 16'h0) && (model_entry[15:12] <= 4'd5) &&
                    (model_entry[7:4] <= 4'd5);
         pulse_start();
         if (start_ok) begin
            chk("rnd_start_err", err, 1'b0);
            expect_load("rnd", model_entry);
            pulse_finished();
            chk("rnd_done_en", enablen, 1'b1);
         end else begin
            chk("rnd_start_err", err, 1'b1);
            chk("rnd_start_load", load, 1'b0);
            chk("rnd_start_busy", busy, 1'b0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
